mux_opa: RTL and testbench
==========================

Name: mux_opa

Overview:
- ALU operand-A selector for the RISC-V execute stage; picks one of three 32-bit sources by a 2-bit select code.
- The combinational result io_opa_alu_in feeds the ALU directly.
- A registered copy and a sticky illegal-select flag are provided for pipeline timing and debug.
- Single clock domain; asynchronous active-high reset.

Parameters:
- XLEN, 32, datapath width of every operand port and of both outputs.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- io_opa_sel  input  2  operand-A select code
- io_opa_rsa  input  XLEN  register-file source rs1 value
- io_opa_imz  input  XLEN  zero-extended immediate (CSR zimm), pre-extended by decode
- io_opa_imu  input  XLEN  upper immediate (LUI/AUIPC), pre-shifted by decode
- io_opa_alu_in  output  XLEN  selected operand, combinational
- io_opa_alu_in_q  output  XLEN  io_opa_alu_in registered one cycle
- io_opa_sel_err  output  1  sticky flag, set when an illegal select code is seen

Behaviour:
- Select decode, purely combinational with zero latency:
  - sel=0 -> io_opa_rsa
  - sel=1 -> io_opa_imz
  - sel=2 -> io_opa_imu
  - sel=3 (illegal) -> all zeros
- io_opa_alu_in responds in the same delta to any input change. No input is latched on the combinational path.
- io_opa_alu_in_q:
  - Loads io_opa_alu_in on every rising clk edge; no enable, so latency is exactly 1 cycle.
  - Reset value 0.
- io_opa_sel_err:
  - Set on the rising edge where io_opa_sel==3 is sampled.
  - Remains 1 until reset; no other clear path.
  - Reset value 0.
- Reset behaviour:
  - Asserting reset immediately (asynchronously) forces io_opa_alu_in_q=0 and io_opa_sel_err=0, regardless of clk.
  - While reset is high, registers hold 0.
  - io_opa_alu_in stays combinational and unaffected by reset.
  - On the first rising edge after deassertion, registers resume normal update.
- Data passes through unmodified: no sign extension, no arithmetic. Bit 31 and the values 0x00000000/0xFFFFFFFF pass through exactly.
- X/undefined sel is not specified; the bench drives only defined values.

Optional Feature:
- Macro MUX_OPA_FWD_EN.
- When defined, two ports are added:
  - io_opa_fwd_vld  input  1
  - io_opa_fwd_data  input  XLEN
- With sel=0 and io_opa_fwd_vld=1, the output is io_opa_fwd_data instead of io_opa_rsa (bypass from a later pipeline stage).
- io_opa_fwd_vld has no effect for sel=1, 2 or 3.
- io_opa_alu_in_q registers the forwarded value identically.
- When undefined, the ports do not exist and sel=0 always yields io_opa_rsa.

Test Plan:
- Mux decode: rsa=0x11111111, imz=0x0000001F, imu=0xABCDE000; step sel 0,1,2,3 -> alu_in = 0x11111111, 0x0000001F, 0xABCDE000, 0x00000000 in the same timestep.
- Register latency: sel=2, imu=0x12345000, then imu=0xFFFFF000 one cycle later -> alu_in_q shows 0x12345000 one edge after the first value and 0xFFFFF000 one edge after the second.
- Sticky error: drive sel=3 for one cycle, then sel=0 -> sel_err=1 after that edge and stays 1 for 10 further cycles; pulsing reset returns it to 0.
- Async reset: with alu_in_q=0xDEADBEEF, assert reset between clock edges -> alu_in_q=0 and sel_err=0 before the next edge; alu_in still tracks its inputs during reset.
- Boundary data: rsa=0xFFFFFFFF, then 0x80000000, then 0x00000000 with sel=0 -> alu_in equals each value bit-exact; no sign change.
- With MUX_OPA_FWD_EN: sel=0, rsa=0x1, fwd_data=0x2, fwd_vld=1 -> alu_in=0x2; fwd_vld=0 -> 0x1; sel=1 with fwd_vld=1 -> imz value.

Source files
------------

// File: rtl/mux_opa.sv
// ALU operand-A selector: combinational 3-way mux plus a registered copy and a sticky illegal-select flag.
// Optional operand forwarding on the rs1 leg is enabled by defining MUX_OPA_FWD_EN.
module mux_opa #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      io_opa_sel,
  input  logic [XLEN-1:0] io_opa_rsa,
  input  logic [XLEN-1:0] io_opa_imz,
  input  logic [XLEN-1:0] io_opa_imu,
`ifdef MUX_OPA_FWD_EN
  input  logic            io_opa_fwd_vld,
  input  logic [XLEN-1:0] io_opa_fwd_data,
`endif
  output logic [XLEN-1:0] io_opa_alu_in,
  output logic [XLEN-1:0] io_opa_alu_in_q,
  output logic            io_opa_sel_err
);

  typedef enum logic [1:0] {
    SEL_RSA = 2'd0,
    SEL_IMZ = 2'd1,
    SEL_IMU = 2'd2,
    SEL_ILL = 2'd3
  } opa_sel_e;

  opa_sel_e        sel;
  logic [XLEN-1:0] rs_val;

  assign sel = opa_sel_e'(io_opa_sel);

`ifdef MUX_OPA_FWD_EN
  // Bypass from a later stage only replaces the register-file leg.
  assign rs_val = io_opa_fwd_vld ? io_opa_fwd_data : io_opa_rsa;
`else
  assign rs_val = io_opa_rsa;
`endif

  always_comb begin
    io_opa_alu_in = '0;
    case (sel)
      SEL_RSA: io_opa_alu_in = rs_val;
      SEL_IMZ: io_opa_alu_in = io_opa_imz;
      SEL_IMU: io_opa_alu_in = io_opa_imu;
      default: io_opa_alu_in = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_opa_alu_in_q <= '0;
      io_opa_sel_err  <= 1'b0;
    end else begin
      io_opa_alu_in_q <= io_opa_alu_in;
      if (sel == SEL_ILL) begin
        io_opa_sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_opa.sv
// Scoreboard bench for mux_opa: driver pushes expected outputs per cycle, a negedge monitor pops and compares.
// Define MUX_OPA_FWD_EN for both RTL and bench to exercise the forwarding ports.
module tb_mux_opa;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [31:0] rsa = '0;
  logic [31:0] imz = '0;
  logic [31:0] imu = '0;
  logic        fwd_vld = 1'b0;
  logic [31:0] fwd_data = '0;
  logic [31:0] alu_in;
  logic [31:0] alu_in_q;
  logic        sel_err;

  mux_opa #(.XLEN(32)) dut (
    .clk             (clk),
    .reset           (rst),
    .io_opa_sel      (sel),
    .io_opa_rsa      (rsa),
    .io_opa_imz      (imz),
    .io_opa_imu      (imu),
`ifdef MUX_OPA_FWD_EN
    .io_opa_fwd_vld  (fwd_vld),
    .io_opa_fwd_data (fwd_data),
`endif
    .io_opa_alu_in   (alu_in),
    .io_opa_alu_in_q (alu_in_q),
    .io_opa_sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] alu_q;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] m_q   = '0;
  logic        m_err = 1'b0;

  // Reference: table of sources indexed by select code, slot 3 is zero.
  function automatic logic [31:0] ref_alu();
    logic [31:0] src [4];
    src[0] = rsa;
`ifdef MUX_OPA_FWD_EN
    if (fwd_vld) src[0] = fwd_data;
`endif
    src[1] = imz;
    src[2] = imu;
    src[3] = 32'h0;
    return src[sel];
  endfunction

  task automatic step(input logic [1:0] s, input logic [31:0] a, input logic [31:0] z,
                      input logic [31:0] u, input logic fv, input logic [31:0] fd, input logic r);
    exp_t e;
    @(posedge clk);
    if (rst) begin
      m_q   = '0;
      m_err = 1'b0;
    end else begin
      m_q = ref_alu();
      if (sel == 2'd3) m_err = 1'b1;
    end
    #1;
    sel = s; rsa = a; imz = z; imu = u; fwd_vld = fv; fwd_data = fd; rst = r;
    if (r) begin
      m_q   = '0;
      m_err = 1'b0;
    end
    e.alu   = ref_alu();
    e.alu_q = m_q;
    e.err   = m_err;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (alu_in !== e.alu) begin
          failures++;
          $display("FAIL alu_in t=%0t got=%08h exp=%08h", $time, alu_in, e.alu);
        end
        checks++;
        if (alu_in_q !== e.alu_q) begin
          failures++;
          $display("FAIL alu_in_q t=%0t got=%08h exp=%08h", $time, alu_in_q, e.alu_q);
        end
        checks++;
        if (sel_err !== e.err) begin
          failures++;
          $display("FAIL sel_err t=%0t got=%0b exp=%0b", $time, sel_err, e.err);
        end
      end
    end
  end

  initial begin : driver
    step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    // Decode
    step(2'd0, 32'h11111111, 32'h0000001F, 32'hABCDE000, 1'b0, 32'h0, 1'b0);
    step(2'd1, 32'h11111111, 32'h0000001F, 32'hABCDE000, 1'b0, 32'h0, 1'b0);
    step(2'd2, 32'h11111111, 32'h0000001F, 32'hABCDE000, 1'b0, 32'h0, 1'b0);
    step(2'd3, 32'h11111111, 32'h0000001F, 32'hABCDE000, 1'b0, 32'h0, 1'b0);
    step(2'd0, 32'h11111111, 32'h0000001F, 32'hABCDE000, 1'b0, 32'h0, 1'b1);
    step(2'd0, 32'h11111111, 32'h0000001F, 32'hABCDE000, 1'b0, 32'h0, 1'b0);
    // Register latency
    step(2'd2, 32'h0, 32'h0, 32'h12345000, 1'b0, 32'h0, 1'b0);
    step(2'd2, 32'h0, 32'h0, 32'hFFFFF000, 1'b0, 32'h0, 1'b0);
    step(2'd2, 32'h0, 32'h0, 32'hFFFFF000, 1'b0, 32'h0, 1'b0);
    // Sticky error then clear by reset
    step(2'd3, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 11; i++) step(2'd0, 32'h5A5A0000 + i, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    // Async reset between edges while alu_in_q holds DEADBEEF
    step(2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(2'd0, 32'h12345678, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(2'd2, 32'h12345678, 32'h0, 32'hCAFE0000, 1'b0, 32'h0, 1'b1);
    step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    // Boundary data
    step(2'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(2'd0, 32'h80000000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(2'd0, 32'h00000000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(2'd1, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b0);
    step(2'd2, 32'h0, 32'h0, 32'h80000000, 1'b0, 32'h0, 1'b0);
    // Forwarding (ignored when the feature is compiled out)
    step(2'd0, 32'h1, 32'h3, 32'h4, 1'b1, 32'h2, 1'b0);
    step(2'd0, 32'h1, 32'h3, 32'h4, 1'b0, 32'h2, 1'b0);
    step(2'd1, 32'h1, 32'h3, 32'h4, 1'b1, 32'h2, 1'b0);
    step(2'd3, 32'h1, 32'h3, 32'h4, 1'b1, 32'h2, 1'b0);
    step(2'd0, 32'h1, 32'h3, 32'h4, 1'b0, 32'h2, 1'b1);
    // Randomized
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 39) == 0));
    end
    step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
